// File: rtl/sysid_probe_master.sv
// Avalon-MM read master: reads system-ID word 0 (ID) and word 1 (timestamp), compares both, reports pass/fail.
// Zero-wait slave gives done 5 cycles after start; waitrequest stretches each read, bounded by TIMEOUT_CYCLES.
module sysid_probe_master #(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_match,
    output logic        ts_match,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ID_REQ,
        S_ID_WAIT,
        S_TS_REQ,
        S_TS_WAIT,
        S_FIN
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          auto_q, auto_d;
    logic          pass_q, pass_d;
    logic          id_match_q, id_match_d;
    logic          ts_match_q, ts_match_d;
    logic          timeout_q, timeout_d;
    logic [31:0]   id_value_q, id_value_d;
    logic [31:0]   ts_value_q, ts_value_d;

    logic          in_req;
    logic          in_wait;
    logic          id_phase;
    logic          accept;
    logic          capture;
    logic          cnt_hit;
    logic          launch;
    logic [CW-1:0] tmo_inc;

    always_comb begin
        in_req   = (state_q == S_ID_REQ) || (state_q == S_TS_REQ);
        in_wait  = (state_q == S_ID_WAIT) || (state_q == S_TS_WAIT);
        id_phase = (state_q == S_ID_REQ) || (state_q == S_ID_WAIT);
        accept   = in_req && !avm_waitrequest;
        // Data may arrive on the very edge the command is accepted.
        capture  = avm_readdatavalid && (in_wait || accept);
        tmo_inc  = tmo_cnt_q + CNT_ONE;
        cnt_hit  = (tmo_inc == CNT_MAX);
        launch   = (state_q == S_IDLE) && (start || auto_q);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Captured data outranks a timeout expiring on the same edge.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (launch) state_d = S_ID_REQ;
            end
            S_ID_REQ: begin
                if (capture)      state_d = S_TS_REQ;
                else if (cnt_hit) state_d = S_FIN;
                else if (accept)  state_d = S_ID_WAIT;
            end
            S_ID_WAIT: begin
                if (capture)      state_d = S_TS_REQ;
                else if (cnt_hit) state_d = S_FIN;
            end
            S_TS_REQ: begin
                if (capture || cnt_hit) state_d = S_FIN;
                else if (accept)        state_d = S_TS_WAIT;
            end
            S_TS_WAIT: begin
                if (capture || cnt_hit) state_d = S_FIN;
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_FIN);
        avm_read    = in_req;
        avm_address = (state_q == S_TS_REQ) || (state_q == S_TS_WAIT);
        pass        = pass_q;
        id_match    = id_match_q;
        ts_match    = ts_match_q;
        timeout     = timeout_q;
        id_value    = id_value_q;
        ts_value    = ts_value_q;
    end

    always_comb begin
        tmo_cnt_d  = tmo_cnt_q;
        auto_d     = 1'b0;
        pass_d     = pass_q;
        id_match_d = id_match_q;
        ts_match_d = ts_match_q;
        timeout_d  = timeout_q;
        id_value_d = id_value_q;
        ts_value_d = ts_value_q;

        if (launch) begin
            tmo_cnt_d  = '0;
            pass_d     = 1'b0;
            id_match_d = 1'b0;
            ts_match_d = 1'b0;
            timeout_d  = 1'b0;
            id_value_d = '0;
            ts_value_d = '0;
        end else if (in_req || in_wait) begin
            tmo_cnt_d = tmo_inc;
            if (capture) begin
                if (id_phase) begin
                    id_value_d = avm_readdata;
                    id_match_d = (avm_readdata == EXPECTED_ID);
                    tmo_cnt_d  = '0;
                end else begin
                    ts_value_d = avm_readdata;
                    ts_match_d = (avm_readdata == EXPECTED_TS);
                end
            end else if (cnt_hit) begin
                timeout_d = 1'b1;
            end
        end

        // Verdict is settled on the edge into FIN so it is valid alongside done.
        if ((state_d == S_FIN) && (state_q != S_FIN)) begin
            pass_d = id_match_d & ts_match_d & ~timeout_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tmo_cnt_q  <= '0;
            auto_q     <= AUTO_START;
            pass_q     <= 1'b0;
            id_match_q <= 1'b0;
            ts_match_q <= 1'b0;
            timeout_q  <= 1'b0;
            id_value_q <= '0;
            ts_value_q <= '0;
        end else begin
            tmo_cnt_q  <= tmo_cnt_d;
            auto_q     <= auto_d;
            pass_q     <= pass_d;
            id_match_q <= id_match_d;
            ts_match_q <= ts_match_d;
            timeout_q  <= timeout_d;
            id_value_q <= id_value_d;
            ts_value_q <= ts_value_d;
        end
    end

endmodule
